// File: rtl/i2s_tx.sv
// Stereo I2S (Philips) transmitter: 16-bit slots, 32 BCLK per frame, one-entry pending buffer.
// All outputs are registered; serial outputs change only on the BCLK falling event.
module i2s_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_l_i,
    input  logic [15:0] sample_r_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic        frame_start_o,
    output logic        underrun_o,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sdata_o
);

    localparam int unsigned     DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            bclk_q;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [31:0]     shift_q;
    logic            lrclk_q, sdata_q;
    logic            frame_start_q, underrun_q;
    logic [31:0]     pend_q, last_q;
    logic            pend_full_q;

    logic            div_wrap;
    logic            fall_evt;
    logic            load_evt;
    logic            accept;
    logic [31:0]     frame_pair;

    always_comb begin
        div_wrap   = (div_cnt_q == DivMax);
        div_cnt_d  = div_wrap ? '0 : div_cnt_q + DivW'(1);
        fall_evt   = div_wrap && bclk_q;
        bit_cnt_d  = bit_cnt_q + 5'd1;
        load_evt   = fall_evt && (bit_cnt_d == 5'd0);
        // An accept on the load clock is not visible to the load: it sees the buffer empty.
        accept     = sample_valid_i && !pend_full_q;
        frame_pair = pend_full_q ? pend_q : last_q;
    end

    // Bit clock divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            if (div_wrap) begin
                bclk_q <= ~bclk_q;
            end
        end
    end

    // Serialiser and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= 5'd31;
            shift_q       <= '0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            last_q        <= '0;
        end else begin
            frame_start_q <= load_evt;
            underrun_q    <= load_evt && !pend_full_q;
            if (fall_evt) begin
                bit_cnt_q <= bit_cnt_d;
                // Word select leads the MSB of each slot by one bit.
                lrclk_q   <= (bit_cnt_d >= 5'd15) && (bit_cnt_d <= 5'd30);
                if (load_evt) begin
                    shift_q <= frame_pair;
                    sdata_q <= frame_pair[31];
                end else begin
                    shift_q <= {shift_q[30:0], 1'b0};
                    sdata_q <= shift_q[30];
                end
            end
            if (load_evt && pend_full_q) begin
                last_q <= pend_q;
            end
        end
    end

    // One-entry pending buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (accept) begin
                pend_q      <= {sample_l_i, sample_r_i};
                pend_full_q <= 1'b1;
            end else if (load_evt && pend_full_q) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    assign sample_ready_o = !pend_full_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_o     = underrun_q;
    assign bclk_o         = bclk_q;
    assign lrclk_o        = lrclk_q;
    assign sdata_o        = sdata_q;

endmodule
